// File: rtl/dmx_frame_sequencer.sv
`timescale 1ns/1ps
// DMX512 frame sequencer: break, mark-after-break, start code, then NUM_SLOTS slot-RAM bytes onto TX.
// Latency: TX drops 1 clk after an accepted frame_tick; slot RAM data is expected 1 clk after rd_en.
// No backpressure: ticks while busy are dropped (overrun); DMX_SEQ_AUTO_REFRESH_EN self-retriggers after a gap.
module dmx_frame_sequencer #(
    parameter int unsigned BIT_DIV    = 48,
    parameter int unsigned BREAK_BITS = 25,
    parameter int unsigned MAB_BITS   = 3,
    parameter int unsigned NUM_SLOTS  = 512,
    parameter logic [7:0]  START_CODE = 8'h00,
    parameter int unsigned GAP_BITS   = 4
) (
    input  logic       clk_In,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       frame_tick,
    output logic       rd_en,
    output logic [8:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       TX,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam int unsigned      DIV_W      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BIT_DIV - 1);
    localparam logic [4:0]       BREAK_LAST = 5'(BREAK_BITS - 1);
    localparam logic [4:0]       MAB_LAST   = 5'(MAB_BITS - 1);
    localparam logic [9:0]       SLOT_LAST  = 10'(NUM_SLOTS);

    if (BIT_DIV < 2 || BREAK_BITS < 1 || BREAK_BITS > 31 || MAB_BITS < 1 || MAB_BITS > 31 ||
        NUM_SLOTS < 1 || NUM_SLOTS > 512 || GAP_BITS < 1 || GAP_BITS > 31) begin : g_param_check
        $error("dmx_frame_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BREAK = 2'd1,
        S_MAB   = 2'd2,
        S_SLOT  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [4:0]       r_bit;
    logic [9:0]       r_slot;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_rd_en;
    logic [8:0]       r_rd_addr;
    logic             r_done;
    logic             r_ovr;

    logic       w_div_end;
    logic       w_start;
    logic       w_cnt_en;
    logic       w_ovr_nxt;
    logic       w_tx_nxt;
    logic       w_rd_en_nxt;
    logic [8:0] w_rd_addr_nxt;
    logic       w_done_nxt;
    logic       w_reload;
    logic       w_ld_start;
    logic       w_ld_data;
    logic       w_shift_en;
    logic       w_slot_inc;

    assign w_div_end = (r_div == '0);
    assign busy      = (r_state != S_IDLE);

`ifdef DMX_SEQ_AUTO_REFRESH_EN
    localparam logic [4:0] GAP_LAST = 5'(GAP_BITS - 1);
    logic r_gap_done;
    logic w_gap_end;

    // IDLE reuses the bit timers to measure the inter-frame gap, then parks once it has elapsed.
    assign w_gap_end = w_div_end && (r_bit == GAP_LAST);
    assign w_start   = enable && (r_gap_done || w_gap_end);
    assign w_cnt_en  = busy || (!r_gap_done && !w_gap_end);
    assign w_ovr_nxt = 1'b0;

    always_ff @(posedge clk_In or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_done <= 1'b0;
        end else if (busy) begin
            r_gap_done <= 1'b0;
        end else if (w_gap_end) begin
            r_gap_done <= 1'b1;
        end
    end
`else
    assign w_start   = frame_tick && enable;
    assign w_cnt_en  = busy;
    assign w_ovr_nxt = frame_tick && busy;
`endif

    always_ff @(posedge clk_In or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tx_nxt      = r_tx;
        w_rd_en_nxt   = 1'b0;
        w_rd_addr_nxt = r_rd_addr;
        w_done_nxt    = 1'b0;
        w_reload      = 1'b0;
        w_ld_start    = 1'b0;
        w_ld_data     = 1'b0;
        w_shift_en    = 1'b0;
        w_slot_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_start) begin
                    w_state_nxt = S_BREAK;
                    w_tx_nxt    = 1'b0;
                    w_reload    = 1'b1;
                end
            end
            S_BREAK: begin
                if (w_div_end && r_bit == BREAK_LAST) begin
                    w_state_nxt   = S_MAB;
                    w_tx_nxt      = 1'b1;
                    w_reload      = 1'b1;
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = 9'd0;
                end
            end
            S_MAB: begin
                if (w_div_end && r_bit == MAB_LAST) begin
                    w_state_nxt = S_SLOT;
                    w_tx_nxt    = 1'b0;
                    w_reload    = 1'b1;
                    w_ld_start  = 1'b1;
                end
            end
            S_SLOT: begin
                // r_bit: 0 start, 1..8 data LSB first, 9..10 stop
                if (w_div_end) begin
                    if (r_bit == 5'd0) begin
                        w_tx_nxt = r_shift[0];
                    end else if (r_bit <= 5'd8) begin
                        w_shift_en = 1'b1;
                        w_tx_nxt   = (r_bit == 5'd8) ? 1'b1 : r_shift[1];
                    end else if (r_bit == 5'd9) begin
                        w_tx_nxt = 1'b1;
                        // slot 1 was fetched during MAB; later slots are fetched one slot ahead
                        if (r_slot != 10'd0 && r_slot != SLOT_LAST) begin
                            w_rd_en_nxt   = 1'b1;
                            w_rd_addr_nxt = r_slot[8:0];
                        end
                    end else begin
                        w_reload = 1'b1;
                        if (r_slot == SLOT_LAST) begin
                            w_state_nxt = S_IDLE;
                            w_tx_nxt    = 1'b1;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_tx_nxt   = 1'b0;
                            w_ld_data  = 1'b1;
                            w_slot_inc = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_In or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= DIV_LAST;
            r_bit     <= 5'd0;
            r_slot    <= 10'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
            r_rd_en   <= 1'b0;
            r_rd_addr <= 9'd0;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_tx      <= w_tx_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_done    <= w_done_nxt;
            r_ovr     <= w_ovr_nxt;

            if (w_reload) begin
                r_div <= DIV_LAST;
                r_bit <= 5'd0;
            end else if (w_cnt_en) begin
                if (w_div_end) begin
                    r_div <= DIV_LAST;
                    r_bit <= r_bit + 5'd1;
                end else begin
                    r_div <= r_div - 1'b1;
                end
            end

            if (w_ld_start) begin
                r_slot <= 10'd0;
            end else if (w_slot_inc) begin
                r_slot <= r_slot + 10'd1;
            end

            if (w_ld_start) begin
                r_shift <= START_CODE;
            end else if (w_ld_data) begin
                r_shift <= rd_data;
            end else if (w_shift_en) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
        end
    end

    assign TX         = r_tx;
    assign rd_en      = r_rd_en;
    assign rd_addr    = r_rd_addr;
    assign frame_done = r_done;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_dmx_frame_sequencer.sv
`timescale 1ns/1ps
// Directed bench for dmx_frame_sequencer with NUM_SLOTS=4 and a 4-byte slot RAM model.
module tb_dmx_frame_sequencer;

    localparam int NS  = 4;
    localparam int LOG = 4200;
    localparam int SLOT0 = 1345;   // first slot cycle relative to the tick cycle
    localparam int DONE  = 3985;   // frame_done cycle relative to the tick cycle

    logic       clk_In = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       frame_tick = 1'b0;
    logic       rd_en;
    logic [8:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       TX;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int addr_q[$];
    logic [7:0] ram [0:511];
    logic [7:0] exp_slot [0:4];
    logic tx_log   [0:LOG-1];
    logic done_log [0:LOG-1];
    logic ovr_log  [0:LOG-1];
    logic busy_log [0:LOG-1];

    always #5 clk_In = ~clk_In;

    dmx_frame_sequencer #(.NUM_SLOTS(NS)) u_dut (
        .clk_In     (clk_In),
        .rst_n      (rst_n),
        .enable     (enable),
        .frame_tick (frame_tick),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .TX         (TX),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always @(posedge clk_In) begin
        if (rd_en) begin
            rd_data <= ram[rd_addr];
            addr_q.push_back(int'(rd_addr));
            rd_cnt++;
        end
    end

    task automatic step();
        @(posedge clk_In);
        #1;
    endtask

    // Index 0 is the tick cycle; a second tick is driven at index tick2_at when >= 0.
    task automatic record(input int tick2_at);
        frame_tick = 1'b1;
        tx_log[0] = TX; done_log[0] = frame_done; ovr_log[0] = overrun; busy_log[0] = busy;
        for (int i = 1; i < LOG; i++) begin
            step();
            tx_log[i] = TX; done_log[i] = frame_done; ovr_log[i] = overrun; busy_log[i] = busy;
            frame_tick = (i == tick2_at);
        end
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        int bad_tx, bad_busy;
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL rst_tx got %b exp 1", TX); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", frame_done); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b exp 0", overrun); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b exp 0", rd_en); end
        checks++; if (rd_addr !== 9'd0) begin errors++; $display("FAIL rst_rd_addr got %0d exp 0", rd_addr); end
        rst_n = 1'b1;
        rd_cnt = 0;
        bad_tx = 0; bad_busy = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (TX !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        checks++; if (bad_tx != 0) begin errors++; $display("FAIL idle_tx cycles_low %0d exp 0", bad_tx); end
        checks++; if (bad_busy != 0) begin errors++; $display("FAIL idle_busy cycles_busy %0d exp 0", bad_busy); end
        checks++; if (rd_cnt != 0) begin errors++; $display("FAIL idle_rd_en pulses %0d exp 0", rd_cnt); end
    endtask

`ifndef DMX_SEQ_AUTO_REFRESH_EN
    task automatic test_enable_gate();
        int nb, no;
        enable = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        nb = 0; no = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b0) nb++;
            if (overrun !== 1'b0) no++;
            step();
        end
        checks++; if (nb != 0) begin errors++; $display("FAIL gate_busy cycles %0d exp 0", nb); end
        checks++; if (no != 0) begin errors++; $display("FAIL gate_ovr cycles %0d exp 0", no); end
    endtask

    task automatic test_frame();
        int idx, nd;
        logic [7:0] b;
        logic [2:0] fr;
        enable = 1'b1;
        addr_q.delete();
        record(-1);
        checks++; if (busy_log[1] !== 1'b1 || tx_log[1] !== 1'b0)
            begin errors++; $display("FAIL frm_start busy %b tx %b exp 1 0", busy_log[1], tx_log[1]); end
        idx = 1;
        while (idx < LOG - 1 && tx_log[idx] === 1'b0) idx++;
        checks++; if (idx != 1201) begin errors++; $display("FAIL frm_break_end got %0d exp 1201", idx); end
        idx = 1201;
        while (idx < LOG - 1 && tx_log[idx] === 1'b1) idx++;
        checks++; if (idx != SLOT0) begin errors++; $display("FAIL frm_mab_end got %0d exp %0d", idx, SLOT0); end
        for (int s = 0; s <= NS; s++) begin
            idx = SLOT0 + s * 528 + 24;
            for (int k = 0; k < 8; k++) b[k] = tx_log[idx + (k + 1) * 48];
            fr = {tx_log[idx], tx_log[idx + 9 * 48], tx_log[idx + 10 * 48]};
            checks++; if (b !== exp_slot[s] || fr !== 3'b011)
                begin errors++; $display("FAIL frm_slot%0d data %h frame %b exp %h 011", s, b, fr, exp_slot[s]); end
        end
        checks++; if (addr_q.size() != 4) begin errors++; $display("FAIL frm_rd_count got %0d exp 4", addr_q.size()); end
        for (int k = 0; k < 4 && k < addr_q.size(); k++) begin
            checks++; if (addr_q[k] != k) begin errors++; $display("FAIL frm_rd_addr%0d got %0d exp %0d", k, addr_q[k], k); end
        end
        nd = 0;
        for (int i = 0; i < LOG; i++) if (done_log[i] === 1'b1) nd++;
        checks++; if (nd != 1 || done_log[DONE] !== 1'b1)
            begin errors++; $display("FAIL frm_done count %0d at_%0d %b exp 1 1", nd, DONE, done_log[DONE]); end
        checks++; if (busy_log[DONE - 1] !== 1'b1 || busy_log[DONE] !== 1'b0)
            begin errors++; $display("FAIL frm_busy_fall %b%b exp 10", busy_log[DONE - 1], busy_log[DONE]); end
    endtask

    task automatic test_overrun();
        int no, nd, idx;
        logic [7:0] b;
        record(2000);
        no = 0; nd = 0;
        for (int i = 0; i < LOG; i++) begin
            if (ovr_log[i] === 1'b1) no++;
            if (done_log[i] === 1'b1) nd++;
        end
        checks++; if (no != 1 || ovr_log[2001] !== 1'b1)
            begin errors++; $display("FAIL ovr_pulse count %0d at_2001 %b exp 1 1", no, ovr_log[2001]); end
        checks++; if (nd != 1 || done_log[DONE] !== 1'b1)
            begin errors++; $display("FAIL ovr_done count %0d exp 1", nd); end
        for (int s = 2; s <= NS; s++) begin
            idx = SLOT0 + s * 528 + 24;
            for (int k = 0; k < 8; k++) b[k] = tx_log[idx + (k + 1) * 48];
            checks++; if (b !== exp_slot[s]) begin errors++; $display("FAIL ovr_slot%0d got %h exp %h", s, b, exp_slot[s]); end
        end
    endtask

    task automatic test_back_to_back();
        int no, i;
        logic seen;
        record(DONE);
        checks++; if (busy_log[DONE + 1] !== 1'b1 || tx_log[DONE + 1] !== 1'b0)
            begin errors++; $display("FAIL b2b_start busy %b tx %b exp 1 0", busy_log[DONE + 1], tx_log[DONE + 1]); end
        no = 0;
        for (int k = 0; k < LOG; k++) if (ovr_log[k] === 1'b1) no++;
        checks++; if (no != 0) begin errors++; $display("FAIL b2b_ovr count %0d exp 0", no); end
        i = LOG - 1;
        seen = 1'b0;
        while (!seen && i < 2 * DONE + 500) begin
            step();
            i++;
            if (frame_done === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen || i != 2 * DONE)
            begin errors++; $display("FAIL b2b_done2 seen %b at %0d exp 1 %0d", seen, i, 2 * DONE); end
        step();
    endtask

    task automatic test_reset_mid();
        int nd, nb;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        repeat (2409) step();
        checks++; if (TX !== 1'b0) begin errors++; $display("FAIL rmid_pre_tx got %b exp 0", TX); end
        rst_n = 1'b0;
        #1;
        checks++; if (TX !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL rmid_async tx %b busy %b exp 1 0", TX, busy); end
        repeat (3) step();
        rst_n = 1'b1;
        nd = 0; nb = 0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (frame_done === 1'b1) nd++;
            if (busy !== 1'b0 || TX !== 1'b1) nb++;
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL rmid_done count %0d exp 0", nd); end
        checks++; if (nb != 0) begin errors++; $display("FAIL rmid_idle bad_cycles %0d exp 0", nb); end
    endtask
`else
    task automatic test_auto_refresh();
        int i, gap, bad, no;
        logic seen;
        enable = 1'b1;
        seen = 1'b0; i = 0; no = 0;
        while (!seen && i < 6000) begin
            frame_tick = (i == 2000);
            step();
            i++;
            if (overrun === 1'b1) no++;
            if (frame_done === 1'b1) seen = 1'b1;
        end
        frame_tick = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL auto_first_done not seen in %0d cycles", i); end
        checks++; if (no != 0) begin errors++; $display("FAIL auto_ovr count %0d exp 0", no); end
        gap = 0; bad = 0;
        while (busy !== 1'b1 && gap < 1000) begin
            if (TX !== 1'b1) bad++;
            step();
            gap++;
        end
        checks++; if (gap != 192) begin errors++; $display("FAIL auto_gap got %0d exp 192", gap); end
        checks++; if (bad != 0) begin errors++; $display("FAIL auto_gap_tx low_cycles %0d exp 0", bad); end
        checks++; if (TX !== 1'b0) begin errors++; $display("FAIL auto_break_tx got %b exp 0", TX); end
        repeat (1000) step();
        enable = 1'b0;
        seen = 1'b0; i = 0;
        while (!seen && i < 4000) begin
            step();
            i++;
            if (frame_done === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen || i != 3984 - 1000)
            begin errors++; $display("FAIL auto_last_done seen %b after %0d exp 1 %0d", seen, i, 3984 - 1000); end
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (busy !== 1'b0 || TX !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL auto_stop bad_cycles %0d exp 0", bad); end
    endtask
`endif

    initial begin
        for (int k = 0; k < 512; k++) ram[k] = 8'h00;
        ram[0] = 8'hA5; ram[1] = 8'h01; ram[2] = 8'hFF; ram[3] = 8'h3C;
        exp_slot[0] = 8'h00; exp_slot[1] = 8'hA5; exp_slot[2] = 8'h01;
        exp_slot[3] = 8'hFF; exp_slot[4] = 8'h3C;
        test_reset();
`ifndef DMX_SEQ_AUTO_REFRESH_EN
        test_enable_gate();
        test_frame();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
`else
        test_auto_refresh();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmx_frame_sequencer.md
# dmx_frame_sequencer

Sequences one complete DMX512 transmission per frame request: break, mark-after-break, start code, then NUM_SLOTS data slots read from an external slot RAM, all driven directly on the TX pin. It runs on the 12.09 MHz internal-oscillator clock with the ResetGen reset. It is started by a single-cycle frame strobe that the top level derives from the 30 Hz or 40 Hz refresh clock.

## Interface
Parameters:
- BIT_DIV, 48: clocks per DMX bit (12.09 MHz / 48 = 251.9 kHz, +0.7 %).
- BREAK_BITS, 25: break length in bit times (100 µs).
- MAB_BITS, 3: mark-after-break length in bit times (12 µs).
- NUM_SLOTS, 512: data slots per frame, 1..512.
- START_CODE, 8'h00: slot 0 value.
- GAP_BITS, 4: inter-frame idle in bit times; used only when auto-refresh is compiled in.

Ports:
- clk_In  in  1  system clock, 12.09 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new frames to start; a frame in progress always completes.
- frame_tick  in  1  single-cycle frame request.
- rd_en  out  1  slot-RAM read strobe.
- rd_addr  out  9  slot-RAM address, 0..NUM_SLOTS-1.
- rd_data  in  8  slot-RAM data, valid exactly 1 cycle after rd_en.
- TX  out  1  DMX serial line; idle/mark = 1.
- busy  out  1  high from the BREAK entry cycle through the last stop bit.
- frame_done  out  1  one-cycle pulse on return to IDLE.
- overrun  out  1  one-cycle pulse when frame_tick is dropped because busy=1.

## Operation
- Reset values: TX=1, busy=0, frame_done=0, overrun=0, rd_en=0, rd_addr=0, state=IDLE. Reset asserted mid-frame forces TX=1 asynchronously and abandons the frame; no frame_done is issued.
- States: IDLE -> BREAK -> MAB -> SLOT -> IDLE.
- IDLE: TX=1. frame_tick with enable=1 enters BREAK on the next cycle.
  - frame_tick with enable=0 is ignored silently.
  - frame_tick while busy=1 is dropped and pulses overrun the next cycle.
- BREAK: TX=0 for BREAK_BITS*BIT_DIV clocks.
- MAB: TX=1 for MAB_BITS*BIT_DIV clocks. At MAB end the shift register loads START_CODE. With NUM_SLOTS≥1, rd_en pulses on the first MAB cycle with rd_addr=0.
- SLOT: each slot is 11 bits, each bit BIT_DIV clocks: start bit 0, data bits 0..7 LSB first, two stop bits 1.
  - The slot index runs 0..NUM_SLOTS; slot 0 is the start code.
  - For slot k≥1, rd_data is captured into the shift register at the start of that slot's start bit.
  - The read for slot k+1 (rd_addr=k) pulses rd_en on the first cycle of slot k's second stop bit. It is not issued after the last slot.
- After the second stop bit of slot NUM_SLOTS: enter IDLE, pulse frame_done in that cycle, busy=0.
- A frame_tick in the frame_done cycle is accepted (not an overrun).
- Counters:
  - Bit-clock divider: ceil(log2 BIT_DIV) bits, reloaded on every state change.
  - Bit counter: 5 bits, covering BREAK_BITS≤31.
  - Slot counter: 10 bits.
  - No wrap-around; every counter is reloaded on entry to its state.

## Timing
- frame_tick at cycle T: busy=1 and TX=0 at T+1.
- BREAK covers T+1 .. T+BREAK_BITS*BIT_DIV.
- Frame length: (BREAK_BITS + MAB_BITS + 11*(NUM_SLOTS+1)) * BIT_DIV clocks.
  - Defaults: 5671*48 = 272208 clocks ≈ 22.5 ms.
  - This fits the 25 ms period of 40 Hz and the 33 ms period of 30 Hz.
- rd_en to capture: 1-cycle RAM latency; data must be stable until the capture, at least 1 bit time later.
- TX is registered; no combinational path from any input to TX.

## Configuration
- DMX_SEQ_AUTO_REFRESH_EN defined:
  - After frame_done, the block holds TX=1 for GAP_BITS*BIT_DIV clocks in IDLE, then starts the next frame if enable=1.
  - frame_tick is ignored and overrun never pulses.
- Undefined: frames start only on frame_tick; GAP_BITS is unused.

## Test plan
- Reset release, then no tick for 10000 cycles -> TX=1, busy=0, rd_en never pulses.
- NUM_SLOTS=4, RAM={8'hA5,8'h01,8'hFF,8'h3C}, one tick:
  - TX low for 1200 clocks, then high for 144 clocks.
  - Slots decode as 00, A5, 01, FF, 3C, each with start bit 0 and two stop bits 1.
  - rd_addr sequence is 0,1,2,3.
  - frame_done fires (25+3+55)*48 = 3984 clocks after busy rises.
- Second tick mid-frame -> overrun pulses 1 cycle; frame unaltered; exactly one frame_done.
- Tick in the same cycle as frame_done -> new BREAK starts next cycle; no overrun.
- rst_n low during slot 2 -> TX=1 in the same cycle; after release, state=IDLE and no frame_done.
- With DMX_SEQ_AUTO_REFRESH_EN, enable=1 -> back-to-back frames with exactly 192 idle clocks between frame_done and the next BREAK. Drop enable -> current frame completes, then TX stays 1.
